reset_sequencer: RTL and testbench
==================================

Name: reset_sequencer

Overview:
- Parametrised reset release controller for N reset domains sharing one clock.
- Qualifies an asynchronous PLL lock input by synchronising and debouncing it. Then holds every reset asserted for a stretch period and releases the channels one at a time, in index order, with a fixed gap between releases.
- Any lock loss or software reset request re-asserts every channel at once.
- Sits between the PLL wrapper and the system/MCU cores.

Parameters:
- NUM_CH, 2, number of reset output channels (≥1).
- STRETCH_CYCLES, 16, cycles all resets stay asserted after lock is qualified (≥1).
- STEP_CYCLES, 8, cycles between consecutive channel releases (≥1).
- LOCK_FILTER, 4, consecutive synchronised-high cycles required to qualify lock (≥1).
- CNT_W, $clog2(max(STRETCH_CYCLES,STEP_CYCLES,LOCK_FILTER)+1), derived counter width (localparam).

Ports:
- clk_i  in  1  sequencer clock.
- rst_ni  in  1  asynchronous active-low reset.
- lock_i  in  1  PLL lock, asynchronous to clk_i.
- sw_rst_i  in  1  synchronous software reset request, level-sensitive.
- rst_no  out  NUM_CH  active-low reset per channel; channel 0 is released first.
- ready_o  out  1  high when all channels are released (RUN state).
- state_o  out  2  current FSM state encoding, for debug.

Behaviour:
- rst_ni low, asynchronously:
  - rst_no = '0, ready_o = 0, state = ASSERT.
  - Synchroniser, filter and counters cleared.
- All outputs are registered, with no combinational path from inputs to outputs.
- Lock synchroniser: 2-flop, giving lock_s. lock_i is never used directly.
- Lock filter:
  - fcnt increments while lock_s=1, saturating at LOCK_FILTER.
  - Registered lock_ok = 1 on the edge fcnt reaches LOCK_FILTER.
  - lock_s=0 clears fcnt and lock_ok on the next edge. There is no filtering on loss.
- FSM states: ASSERT=0, WAIT=1, RELEASE=2, RUN=3.
- ASSERT:
  - rst_no all 0, cnt=0, idx=0.
  - Goes to WAIT when lock_ok=1 and sw_rst_i=0.
- WAIT:
  - cnt increments each cycle.
  - On the edge with cnt==STRETCH_CYCLES-1: rst_no[0]<=1, cnt<=0, idx<=1.
  - Next state is RELEASE, or RUN with ready_o<=1 if NUM_CH==1.
- RELEASE:
  - cnt increments each cycle.
  - On the edge with cnt==STEP_CYCLES-1: rst_no[idx]<=1, cnt<=0, idx<=idx+1.
  - If idx==NUM_CH-1, next state is RUN and ready_o<=1 on that same edge.
- RUN: holds all channels released until an abort condition.
- Abort, from any state except ASSERT: lock_ok==0 or sw_rst_i==1.
  - On the next edge: state<=ASSERT, rst_no<='0, ready_o<=0, cnt<=0, idx<=0.
  - Abort has priority over any release scheduled on the same edge.
- sw_rst_i held high keeps the FSM in ASSERT. Re-sequencing starts the cycle after it drops, if lock_ok=1.
- Released channels never re-assert individually; re-assertion is always all-channels.
- Counters never wrap: cnt is cleared on every transition.
- idx width is $clog2(NUM_CH)+1 so it never overflows.

Decomposition:
- reset_seq_pkg:
  - state_e enum (2-bit, explicit values above).
  - Helper function for max of three ints, used for CNT_W.
- One sub-module, lock_qualifier: 2-flop synchroniser plus saturating filter. Parameter LOCK_FILTER; ports clk_i, rst_ni, lock_i, lock_ok_o.

Test Plan:
- Defaults, lock_i rises before edge 1 and stays high:
  - lock_ok=1 after edge 6, WAIT after edge 7.
  - rst_no=2'b01 after edge 23.
  - rst_no=2'b11 and ready_o=1 after edge 31; state_o=3.
- Lock glitch: lock_i high for 3 cycles then low, then high permanently.
  - No exit from ASSERT during the glitch.
  - The sequence restarts from the final rise with identical 23/31-cycle offsets.
- Lock loss mid-sequence: lock_i drops when rst_no=2'b01.
  - Synchroniser + filter latency applies, then rst_no=2'b00, ready_o=0, state_o=0 one edge after lock_ok falls.
  - Re-lock gives full STRETCH_CYCLES again.
- sw_rst_i pulse, 1 cycle, in RUN: rst_no=2'b00 on the next edge, then channel 0 releases 17 edges later and channel 1 8 edges after that.
- rst_ni asserted asynchronously mid-RELEASE: outputs zero immediately without a clock; after deassertion the full sequence repeats.
- NUM_CH=4, STEP_CYCLES=1, STRETCH_CYCLES=1: rst_no goes 0001→0011→0111→1111 on consecutive edges, with ready_o rising alongside 1111.

Source files
------------

// File: rtl/reset_seq_pkg.sv
// Shared types and helpers for the reset sequencer.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_WAIT    = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RUN     = 2'd3
  } state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/lock_qualifier.sv
// Two-flop lock synchroniser followed by a saturating high-level filter.
module lock_qualifier #(
  parameter int LOCK_FILTER = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic lock_i,
  output logic lock_ok_o
);

  localparam int FW = $clog2(LOCK_FILTER + 1);

  logic [1:0]    sync_q;
  logic          lock_s;
  logic [FW-1:0] fcnt;

  assign lock_s = sync_q[1];

  // Bring the asynchronous lock into the clock domain.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], lock_i};
    end
  end

  // Count consecutive high cycles; lock is qualified on the edge the count saturates,
  // and any low cycle drops it immediately.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fcnt      <= '0;
      lock_ok_o <= 1'b0;
    end else if (!lock_s) begin
      fcnt      <= '0;
      lock_ok_o <= 1'b0;
    end else if (fcnt != FW'(LOCK_FILTER)) begin
      fcnt      <= fcnt + 1'b1;
      lock_ok_o <= (fcnt == FW'(LOCK_FILTER - 1));
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Reset release controller: qualify PLL lock, stretch, then release channels in index order.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_CH         = 2,
  parameter int STRETCH_CYCLES = 16,
  parameter int STEP_CYCLES    = 8,
  parameter int LOCK_FILTER    = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              lock_i,
  input  logic              sw_rst_i,
  output logic [NUM_CH-1:0] rst_no,
  output logic              ready_o,
  output logic [1:0]        state_o
);

  localparam int CNT_W = $clog2(max3(STRETCH_CYCLES, STEP_CYCLES, LOCK_FILTER) + 1);
  localparam int IDX_W = $clog2(NUM_CH) + 1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [NUM_CH-1:0]  rst_d;
  logic               ready_d;
  logic               lock_ok;
  logic               abort;

  lock_qualifier #(
    .LOCK_FILTER(LOCK_FILTER)
  ) u_lock (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .lock_i   (lock_i),
    .lock_ok_o(lock_ok)
  );

  assign abort   = !lock_ok || sw_rst_i;
  assign state_o = state_q;

  // State, counters and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_ASSERT;
      cnt_q   <= '0;
      idx_q   <= '0;
      rst_no  <= '0;
      ready_o <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rst_no  <= rst_d;
      ready_o <= ready_d;
    end
  end

  // Next-state and next-output logic; abort is checked first so it overrides a due release.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rst_d   = rst_no;
    ready_d = ready_o;

    if (state_q != ST_ASSERT && abort) begin
      state_d = ST_ASSERT;
      cnt_d   = '0;
      idx_d   = '0;
      rst_d   = '0;
      ready_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_ASSERT: begin
          cnt_d   = '0;
          idx_d   = '0;
          rst_d   = '0;
          ready_d = 1'b0;
          if (lock_ok && !sw_rst_i) state_d = ST_WAIT;
        end

        ST_WAIT: begin
          if (cnt_q == CNT_W'(STRETCH_CYCLES - 1)) begin
            rst_d[0] = 1'b1;
            cnt_d    = '0;
            idx_d    = IDX_W'(1);
            if (NUM_CH == 1) begin
              state_d = ST_RUN;
              ready_d = 1'b1;
            end else begin
              state_d = ST_RELEASE;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        ST_RELEASE: begin
          if (cnt_q == CNT_W'(STEP_CYCLES - 1)) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
              if (idx_q == IDX_W'(i)) rst_d[i] = 1'b1;
            end
            cnt_d = '0;
            idx_d = idx_q + 1'b1;
            if (idx_q == IDX_W'(NUM_CH - 1)) begin
              state_d = ST_RUN;
              ready_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        ST_RUN: begin
          cnt_d = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: default 2-channel build and a fast 4-channel build.
module tb_reset_sequencer;

  logic       clk;
  logic       rst_n;
  logic       lock;
  logic       sw_rst;
  logic [1:0] rst_a;
  logic       rdy_a;
  logic [1:0] st_a;
  logic [3:0] rst_b;
  logic       rdy_b;
  logic [1:0] st_b;

  int vec;
  int miss;
  int ec;

  reset_sequencer u_dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .lock_i  (lock),
    .sw_rst_i(sw_rst),
    .rst_no  (rst_a),
    .ready_o (rdy_a),
    .state_o (st_a)
  );

  reset_sequencer #(
    .NUM_CH        (4),
    .STRETCH_CYCLES(1),
    .STEP_CYCLES   (1),
    .LOCK_FILTER   (4)
  ) u_fast (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .lock_i  (lock),
    .sw_rst_i(sw_rst),
    .rst_no  (rst_b),
    .ready_o (rdy_b),
    .state_o (st_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance to 1 time unit after the k-th edge since the last start.
  task automatic wait_until(input int k);
    while (ec < k) begin
      @(posedge clk);
      #1;
      ec++;
    end
  endtask

  // Pulse reset, then release it with lock at the given level; edge 1 is the next posedge.
  task automatic start(input logic lk);
    @(posedge clk);
    #1;
    rst_n  = 1'b0;
    lock   = 1'b0;
    sw_rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    lock  = lk;
    ec    = 0;
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1;
    rst_n  = 1'b0;
    lock   = 1'b1;
    sw_rst = 1'b0;
    #2;
    vec++;
    if ({rst_a, rdy_a, st_a} !== 5'b00_0_00) begin
      miss++;
      $display("FAIL reset_a: got %b want %b", {rst_a, rdy_a, st_a}, 5'b00_0_00);
    end
    vec++;
    if ({rst_b, rdy_b, st_b} !== 7'b0000_0_00) begin
      miss++;
      $display("FAIL reset_b: got %b want %b", {rst_b, rdy_b, st_b}, 7'b0000_0_00);
    end
    repeat (3) @(posedge clk);
    #1;
    vec++;
    if ({rst_a, rdy_a, st_a} !== 5'b00_0_00) begin
      miss++;
      $display("FAIL reset_held: got %b want %b", {rst_a, rdy_a, st_a}, 5'b00_0_00);
    end
  endtask

  task automatic test_nominal();
    start(1'b1);
    wait_until(6);
    vec++;
    if ({rst_a, rdy_a, st_a} !== 5'b00_0_00) begin
      miss++;
      $display("FAIL nominal@6: got %b want %b", {rst_a, rdy_a, st_a}, 5'b00_0_00);
    end
    wait_until(7);
    vec++;
    if ({rst_a, rdy_a, st_a} !== 5'b00_0_01) begin
      miss++;
      $display("FAIL nominal@7: got %b want %b", {rst_a, rdy_a, st_a}, 5'b00_0_01);
    end
    wait_until(22);
    vec++;
    if ({rst_a, rdy_a, st_a} !== 5'b00_0_01) begin
      miss++;
      $display("FAIL nominal@22: got %b want %b", {rst_a, rdy_a, st_a}, 5'b00_0_01);
    end
    wait_until(23);
    vec++;
    if ({rst_a, rdy_a, st_a} !== 5'b01_0_10) begin
      miss++;
      $display("FAIL nominal@23: got %b want %b", {rst_a, rdy_a, st_a}, 5'b01_0_10);
    end
    wait_until(30);
    vec++;
    if ({rst_a, rdy_a, st_a} !== 5'b01_0_10) begin
      miss++;
      $display("FAIL nominal@30: got %b want %b", {rst_a, rdy_a, st_a}, 5'b01_0_10);
    end
    wait_until(31);
    vec++;
    if ({rst_a, rdy_a, st_a} !== 5'b11_1_11) begin
      miss++;
      $display("FAIL nominal@31: got %b want %b", {rst_a, rdy_a, st_a}, 5'b11_1_11);
    end
    wait_until(40);
    vec++;
    if ({rst_a, rdy_a, st_a} !== 5'b11_1_11) begin
      miss++;
      $display("FAIL nominal@40: got %b want %b", {rst_a, rdy_a, st_a}, 5'b11_1_11);
    end
  endtask

  task automatic test_glitch();
    start(1'b1);
    wait_until(3);
    lock = 1'b0;
    for (int k = 4; k <= 10; k += 3) begin
      wait_until(k);
      vec++;
      if ({rst_a, rdy_a, st_a} !== 5'b00_0_00) begin
        miss++;
        $display("FAIL glitch@%0d: got %b want %b", k, {rst_a, rdy_a, st_a}, 5'b00_0_00);
      end
    end
    lock = 1'b1;
    wait_until(16);
    vec++;
    if ({rst_a, rdy_a, st_a} !== 5'b00_0_00) begin
      miss++;
      $display("FAIL glitch@16: got %b want %b", {rst_a, rdy_a, st_a}, 5'b00_0_00);
    end
    wait_until(17);
    vec++;
    if ({rst_a, rdy_a, st_a} !== 5'b00_0_01) begin
      miss++;
      $display("FAIL glitch@17: got %b want %b", {rst_a, rdy_a, st_a}, 5'b00_0_01);
    end
    wait_until(32);
    vec++;
    if ({rst_a, rdy_a, st_a} !== 5'b00_0_01) begin
      miss++;
      $display("FAIL glitch@32: got %b want %b", {rst_a, rdy_a, st_a}, 5'b00_0_01);
    end
    wait_until(33);
    vec++;
    if ({rst_a, rdy_a, st_a} !== 5'b01_0_10) begin
      miss++;
      $display("FAIL glitch@33: got %b want %b", {rst_a, rdy_a, st_a}, 5'b01_0_10);
    end
    wait_until(41);
    vec++;
    if ({rst_a, rdy_a, st_a} !== 5'b11_1_11) begin
      miss++;
      $display("FAIL glitch@41: got %b want %b", {rst_a, rdy_a, st_a}, 5'b11_1_11);
    end
  endtask

  task automatic test_lock_loss();
    start(1'b1);
    wait_until(23);
    lock = 1'b0;
    wait_until(26);
    vec++;
    if ({rst_a, rdy_a, st_a} !== 5'b01_0_10) begin
      miss++;
      $display("FAIL loss@26: got %b want %b", {rst_a, rdy_a, st_a}, 5'b01_0_10);
    end
    wait_until(27);
    vec++;
    if ({rst_a, rdy_a, st_a} !== 5'b00_0_00) begin
      miss++;
      $display("FAIL loss@27: got %b want %b", {rst_a, rdy_a, st_a}, 5'b00_0_00);
    end
    lock = 1'b1;
    wait_until(33);
    vec++;
    if ({rst_a, rdy_a, st_a} !== 5'b00_0_00) begin
      miss++;
      $display("FAIL relock@33: got %b want %b", {rst_a, rdy_a, st_a}, 5'b00_0_00);
    end
    wait_until(34);
    vec++;
    if ({rst_a, rdy_a, st_a} !== 5'b00_0_01) begin
      miss++;
      $display("FAIL relock@34: got %b want %b", {rst_a, rdy_a, st_a}, 5'b00_0_01);
    end
    wait_until(49);
    vec++;
    if ({rst_a, rdy_a, st_a} !== 5'b00_0_01) begin
      miss++;
      $display("FAIL relock@49: got %b want %b", {rst_a, rdy_a, st_a}, 5'b00_0_01);
    end
    wait_until(50);
    vec++;
    if ({rst_a, rdy_a, st_a} !== 5'b01_0_10) begin
      miss++;
      $display("FAIL relock@50: got %b want %b", {rst_a, rdy_a, st_a}, 5'b01_0_10);
    end
    wait_until(58);
    vec++;
    if ({rst_a, rdy_a, st_a} !== 5'b11_1_11) begin
      miss++;
      $display("FAIL relock@58: got %b want %b", {rst_a, rdy_a, st_a}, 5'b11_1_11);
    end
  endtask

  task automatic test_sw_reset();
    start(1'b1);
    wait_until(35);
    sw_rst = 1'b1;
    wait_until(36);
    sw_rst = 1'b0;
    vec++;
    if ({rst_a, rdy_a, st_a} !== 5'b00_0_00) begin
      miss++;
      $display("FAIL swpulse@36: got %b want %b", {rst_a, rdy_a, st_a}, 5'b00_0_00);
    end
    wait_until(37);
    vec++;
    if ({rst_a, rdy_a, st_a} !== 5'b00_0_01) begin
      miss++;
      $display("FAIL swpulse@37: got %b want %b", {rst_a, rdy_a, st_a}, 5'b00_0_01);
    end
    wait_until(52);
    vec++;
    if ({rst_a, rdy_a, st_a} !== 5'b00_0_01) begin
      miss++;
      $display("FAIL swpulse@52: got %b want %b", {rst_a, rdy_a, st_a}, 5'b00_0_01);
    end
    wait_until(53);
    vec++;
    if ({rst_a, rdy_a, st_a} !== 5'b01_0_10) begin
      miss++;
      $display("FAIL swpulse@53: got %b want %b", {rst_a, rdy_a, st_a}, 5'b01_0_10);
    end
    wait_until(60);
    vec++;
    if ({rst_a, rdy_a, st_a} !== 5'b01_0_10) begin
      miss++;
      $display("FAIL swpulse@60: got %b want %b", {rst_a, rdy_a, st_a}, 5'b01_0_10);
    end
    wait_until(61);
    vec++;
    if ({rst_a, rdy_a, st_a} !== 5'b11_1_11) begin
      miss++;
      $display("FAIL swpulse@61: got %b want %b", {rst_a, rdy_a, st_a}, 5'b11_1_11);
    end
  endtask

  task automatic test_sw_hold();
    start(1'b1);
    wait_until(31);
    sw_rst = 1'b1;
    for (int k = 32; k <= 40; k += 4) begin
      wait_until(k);
      vec++;
      if ({rst_a, rdy_a, st_a} !== 5'b00_0_00) begin
        miss++;
        $display("FAIL swhold@%0d: got %b want %b", k, {rst_a, rdy_a, st_a}, 5'b00_0_00);
      end
    end
    sw_rst = 1'b0;
    wait_until(41);
    vec++;
    if ({rst_a, rdy_a, st_a} !== 5'b00_0_01) begin
      miss++;
      $display("FAIL swhold@41: got %b want %b", {rst_a, rdy_a, st_a}, 5'b00_0_01);
    end
    wait_until(57);
    vec++;
    if ({rst_a, rdy_a, st_a} !== 5'b01_0_10) begin
      miss++;
      $display("FAIL swhold@57: got %b want %b", {rst_a, rdy_a, st_a}, 5'b01_0_10);
    end
  endtask

  task automatic test_async_reset();
    start(1'b1);
    wait_until(26);
    vec++;
    if ({rst_a, rdy_a, st_a} !== 5'b01_0_10) begin
      miss++;
      $display("FAIL async_pre: got %b want %b", {rst_a, rdy_a, st_a}, 5'b01_0_10);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vec++;
    if ({rst_a, rdy_a, st_a} !== 5'b00_0_00) begin
      miss++;
      $display("FAIL async_now: got %b want %b", {rst_a, rdy_a, st_a}, 5'b00_0_00);
    end
    start(1'b1);
    wait_until(22);
    vec++;
    if ({rst_a, rdy_a, st_a} !== 5'b00_0_01) begin
      miss++;
      $display("FAIL async_rerun@22: got %b want %b", {rst_a, rdy_a, st_a}, 5'b00_0_01);
    end
    wait_until(23);
    vec++;
    if ({rst_a, rdy_a, st_a} !== 5'b01_0_10) begin
      miss++;
      $display("FAIL async_rerun@23: got %b want %b", {rst_a, rdy_a, st_a}, 5'b01_0_10);
    end
    wait_until(31);
    vec++;
    if ({rst_a, rdy_a, st_a} !== 5'b11_1_11) begin
      miss++;
      $display("FAIL async_rerun@31: got %b want %b", {rst_a, rdy_a, st_a}, 5'b11_1_11);
    end
  endtask

  task automatic test_fast();
    logic [6:0] exp_tbl [0:4];
    exp_tbl[0] = 7'b0000_0_01;
    exp_tbl[1] = 7'b0001_0_10;
    exp_tbl[2] = 7'b0011_0_10;
    exp_tbl[3] = 7'b0111_0_10;
    exp_tbl[4] = 7'b1111_1_11;
    start(1'b1);
    wait_until(6);
    vec++;
    if ({rst_b, rdy_b, st_b} !== 7'b0000_0_00) begin
      miss++;
      $display("FAIL fast@6: got %b want %b", {rst_b, rdy_b, st_b}, 7'b0000_0_00);
    end
    for (int k = 0; k < 5; k++) begin
      wait_until(7 + k);
      vec++;
      if ({rst_b, rdy_b, st_b} !== exp_tbl[k]) begin
        miss++;
        $display("FAIL fast@%0d: got %b want %b", 7 + k, {rst_b, rdy_b, st_b}, exp_tbl[k]);
      end
    end
    wait_until(20);
    vec++;
    if ({rst_b, rdy_b, st_b} !== 7'b1111_1_11) begin
      miss++;
      $display("FAIL fast@20: got %b want %b", {rst_b, rdy_b, st_b}, 7'b1111_1_11);
    end
  endtask

  initial begin
    vec    = 0;
    miss   = 0;
    ec     = 0;
    rst_n  = 1'b0;
    lock   = 1'b0;
    sw_rst = 1'b0;
    test_reset();
    test_nominal();
    test_glitch();
    test_lock_loss();
    test_sw_reset();
    test_sw_hold();
    test_async_reset();
    test_fast();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
